// File: rtl/top_multi_iobus.sv
// Board-level top of the multi-cycle I/O-bus demo.
// Ports: clk_50mhz, rst_n (async low), BTN[4:0], SW[7:0] in;
//   LED[7:0], SEGMENT[7:0], AN_SEL[3:0], LCDRS/LCDRW/LCDE, LCDDAT[3:0] out.
module top_multi_iobus #(
    parameter int DEB_CYCLES = 50000,
    parameter int SCAN_BIT   = 17
) (
    input  logic       clk_50mhz,
    input  logic       rst_n,
    input  logic [4:0] BTN,
    input  logic [7:0] SW,
    output logic [7:0] LED,
    output logic [7:0] SEGMENT,
    output logic [3:0] AN_SEL,
    output logic       LCDRS,
    output logic       LCDRW,
    output logic       LCDE,
    output logic [3:0] LCDDAT
);

    localparam int DW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_SW, S_RD_BTN, S_EXEC, S_WR_LED, S_WR_SEG
    } state_t;

    state_t      state;
    logic [4:0]  btn_s1, btn_s2;
    logic [7:0]  sw_s1, sw_s2;
    logic [DW-1:0] deb_cnt [5];
    logic [4:0]  deb;
    logic [4:0]  rise;
    logic [4:0]  pend;
    logic [4:0]  snap;
    logic [4:0]  clr;
    logic [7:0]  sw_r;
    logic [15:0] cnt;
    logic [15:0] seg_reg;
    logic [31:0] clkdiv;

    logic [1:0]  addr;
    logic        we;
    logic [15:0] wdata;
    logic [15:0] rdata;

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            sw_s1  <= '0;
            sw_s2  <= '0;
        end else begin
            btn_s1 <= BTN;
            btn_s2 <= btn_s1;
            sw_s1  <= SW;
            sw_s2  <= sw_s1;
        end
    end

    // A level is accepted only after DEB_CYCLES consecutive differing clocks.
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            deb <= '0;
            for (int i = 0; i < 5; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (btn_s2[i] != deb[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        deb[i]     <= btn_s2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        rise = '0;
        for (int i = 0; i < 5; i++)
            rise[i] = btn_s2[i] & ~deb[i] & (deb_cnt[i] == DEB_LAST);
    end

    // Only the highest-priority snapshot bit is consumed; bit 3 is dropped.
    always_comb begin
        clr = '0;
        if (state == S_EXEC) begin
            clr[3] = snap[3];
            if (snap[4])      clr[4] = 1'b1;
            else if (snap[2]) clr[2] = 1'b1;
            else if (snap[1]) clr[1] = 1'b1;
            else if (snap[0]) clr[0] = 1'b1;
        end
    end

    always_comb begin
        addr  = 2'd0;
        we    = 1'b0;
        wdata = '0;
        case (state)
            S_RD_SW:  addr = 2'd0;
            S_RD_BTN: addr = 2'd1;
            S_WR_LED: begin
                addr  = 2'd2;
                we    = 1'b1;
                wdata = {8'h00, sw_r[7] ? cnt[7:0] : sw_r};
            end
            S_WR_SEG: begin
                addr  = 2'd3;
                we    = 1'b1;
                wdata = cnt;
            end
            default: ;
        endcase
    end

    always_comb begin
        rdata = '0;
        case (addr)
            2'd0: rdata = {8'h00, sw_s2};
            2'd1: rdata = {11'h000, deb};
            2'd2: rdata = {8'h00, LED};
            2'd3: rdata = seg_reg;
            default: ;
        endcase
    end

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            LED     <= '0;
            seg_reg <= '0;
            sw_r    <= '0;
            snap    <= '0;
            pend    <= '0;
        end else begin
            // A new edge in the clearing cycle survives.
            pend <= (pend & ~clr) | rise;
            if (we && addr == 2'd2) LED     <= wdata[7:0];
            if (we && addr == 2'd3) seg_reg <= wdata;
            case (state)
                S_IDLE:   state <= S_RD_SW;
                S_RD_SW: begin
                    sw_r  <= rdata[7:0];
                    state <= S_RD_BTN;
                end
                S_RD_BTN: begin
                    snap  <= pend;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (snap[4])      cnt <= '0;
                    else if (snap[2]) cnt <= {8'h00, sw_r};
                    else if (snap[1]) cnt <= cnt - 1'b1;
                    else if (snap[0]) cnt <= cnt + 1'b1;
                    state <= S_WR_LED;
                end
                S_WR_LED: state <= S_WR_SEG;
                S_WR_SEG: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    logic [1:0] d;
    logic [3:0] nib;
    logic [6:0] hex;

    assign d   = clkdiv[SCAN_BIT -: 2];
    assign nib = seg_reg[{d, 2'b00} +: 4];

    always_comb begin
        hex = 7'h7F;
        case (nib)
            4'h0: hex = 7'h40;
            4'h1: hex = 7'h79;
            4'h2: hex = 7'h24;
            4'h3: hex = 7'h30;
            4'h4: hex = 7'h19;
            4'h5: hex = 7'h12;
            4'h6: hex = 7'h02;
            4'h7: hex = 7'h78;
            4'h8: hex = 7'h00;
            4'h9: hex = 7'h10;
            4'hA: hex = 7'h08;
            4'hB: hex = 7'h03;
            4'hC: hex = 7'h46;
            4'hD: hex = 7'h21;
            4'hE: hex = 7'h06;
            4'hF: hex = 7'h0E;
            default: hex = 7'h7F;
        endcase
    end

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            clkdiv  <= '0;
            SEGMENT <= 8'hFF;
            AN_SEL  <= 4'hF;
        end else begin
            clkdiv  <= clkdiv + 1'b1;
            SEGMENT <= {1'b1, hex};
            AN_SEL  <= ~(4'b0001 << d);
        end
    end

    assign LCDRS  = 1'b0;
    assign LCDRW  = 1'b0;
    assign LCDE   = 1'b0;
    assign LCDDAT = 4'h0;

    // High read bits and upper scan-divider bits are intentionally unused.
    logic unused_bits;
    assign unused_bits = ^{rdata[15:8], wdata[15:8], clkdiv};

endmodule

// File: tb/tb_top_multi_iobus.sv
// Scoreboard bench for top_multi_iobus (DEB_CYCLES=4, SCAN_BIT=3).
// Expected LED/counter pushed with stimulus, popped when outputs settle.
module tb_top_multi_iobus;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] btn = '0;
    logic [7:0] sw = '0;
    logic [7:0] led;
    logic [7:0] segment;
    logic [3:0] an_sel;
    logic       lcdrs, lcdrw, lcde;
    logic [3:0] lcddat;

    always #5 clk = ~clk;

    top_multi_iobus #(.DEB_CYCLES(4), .SCAN_BIT(3)) dut (
        .clk_50mhz(clk),
        .rst_n(rst_n),
        .BTN(btn),
        .SW(sw),
        .LED(led),
        .SEGMENT(segment),
        .AN_SEL(an_sel),
        .LCDRS(lcdrs),
        .LCDRW(lcdrw),
        .LCDE(lcde),
        .LCDDAT(lcddat)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0]  led_q [$];
    logic [15:0] cnt_q [$];

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'h40; 4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24; 4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19; 4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02; 4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00; 4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08; 4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46; 4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06; default: seg7 = 7'h0E;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [4:0] m, input int hi = 10);
        btn = btn | m;
        tick(hi);
        btn = btn & ~m;
        tick(10);
    endtask

    task automatic expect_out(input logic [7:0] l, input logic [15:0] c);
        led_q.push_back(l);
        cnt_q.push_back(c);
    endtask

    task automatic scan(input logic [15:0] c);
        logic [3:0] seen;
        int d;
        seen = '0;
        for (int k = 0; k < 32; k++) begin
            tick(1);
            d = -1;
            case (an_sel)
                4'hE: d = 0;
                4'hD: d = 1;
                4'hB: d = 2;
                4'h7: d = 3;
                default: chk("an_onehot", 16'(an_sel), 16'hE);
            endcase
            if (d >= 0) begin
                seen[d] = 1'b1;
                chk($sformatf("seg_d%0d", d), 16'(segment),
                    16'({1'b1, seg7(c[4*d +: 4])}));
            end
        end
        chk("scan_all", 16'(seen), 16'hF);
    endtask

    task automatic drain(input string tag);
        logic [7:0]  el;
        logic [15:0] ec;
        tick(16);
        if (led_q.size() == 0 || cnt_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 16'd1, 16'd0);
        end else begin
            el = led_q.pop_front();
            ec = cnt_q.pop_front();
            chk({tag, "_led"}, 16'(led), 16'(el));
            scan(ec);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            btn = 5'($urandom);
            sw  = 8'($urandom);
            tick(1);
        end
        chk("rst_led", 16'(led), 16'h00);
        chk("rst_seg", 16'(segment), 16'hFF);
        chk("rst_an", 16'(an_sel), 16'hF);
        chk("rst_lcd", 16'({lcdrs, lcdrw, lcde, lcddat}), 16'h0);
        btn = '0;
        sw  = '0;
        tick(2);
        rst_n = 1'b1;

        sw = 8'h5A; expect_out(8'h5A, 16'h0000); drain("sw5a");
        sw = 8'h25; expect_out(8'h25, 16'h0000); drain("sw25");
        sw = 8'h80; expect_out(8'h00, 16'h0000); drain("sw80");

        for (int i = 0; i < 3; i++) press(5'b00001);
        expect_out(8'h03, 16'h0003); drain("inc3");
        press(5'b00001, 2);
        expect_out(8'h03, 16'h0003); drain("glitch");

        sw = 8'h12;
        press(5'b00100);
        expect_out(8'h12, 16'h0012); drain("load12");
        for (int i = 0; i < 19; i++) press(5'b00010);
        expect_out(8'h12, 16'hFFFF); drain("dec_wrap");
        sw = 8'h80;
        expect_out(8'hFF, 16'hFFFF); drain("led_cnt");

        press(5'b10001);
        expect_out(8'h01, 16'h0001); drain("clr_then_inc");
        press(5'b01000);
        expect_out(8'h01, 16'h0001); drain("btn3_nop");

        press(5'b00010);
        press(5'b00010);
        expect_out(8'hFF, 16'hFFFF); drain("dec2");
        press(5'b00001);
        expect_out(8'h00, 16'h0000); drain("inc_wrap");

        sw = 8'hEF;
        press(5'b00100);
        expect_out(8'hEF, 16'h00EF); drain("loadef");
        press(5'b00001);
        expect_out(8'hF0, 16'h00F0); drain("inc_f0");

        btn = 5'b00001;
        tick(7);
        rst_n = 1'b0;
        tick(1);
        chk("mid_rst_led", 16'(led), 16'h00);
        chk("mid_rst_an", 16'(an_sel), 16'hF);
        btn = '0;
        tick(3);
        rst_n = 1'b1;
        expect_out(8'h00, 16'h0000); drain("post_rst");
        chk("lcd_idle", 16'({lcdrs, lcdrw, lcde, lcddat}), 16'h0);
        chk("sb_left", 16'(led_q.size() + cnt_q.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
